button_debounce_sched: RTL and testbench

//  Round-robin scheduler that shares one debounce timer among N_BTN pre-synchronized buttons.
//  A button whose level differs from its debounced (stable) level requests the timer. When the

---
 rtl/button_debounce_sched.sv | 130 +++++++++++++
 tb/tb_button_debounce_sched.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce_sched.sv
// -----------------------------------------------------------------------------
// button_debounce_sched
//
// Shares one debounce timer among N_BTN buttons that have already been
// synchronized to clk. A button whose raw level differs from its debounced
// level is "pending". The pending buttons are served round-robin, one at a time.
// The granted button must hold its new level for DEBOUNCE = 2**(WIDTH_CNT-1)
// cycles. When it does, the debounced level is committed and a one-cycle
// press or release pulse is emitted. If the button returns to its debounced
// level while it is being timed, the grant is dropped without an event.
//
// Ports
//   clk            in   clock, all logic on posedge
//   reset          in   synchronous, active-high reset
//   btn_sync       in   [N_BTN-1:0]  synchronized raw button levels
//   btn_stable     out  [N_BTN-1:0]  debounced levels
//   press_pulse    out  [N_BTN-1:0]  1-cycle pulse on a debounced 0->1
//   release_pulse  out  [N_BTN-1:0]  1-cycle pulse on a debounced 1->0
//   busy           out  timer is granted to a button (state WAIT)
//   active_idx     out  index of the granted button, valid while busy=1
//   press_total    out  [CNT_W-1:0]  wrapping count of committed presses
//   state_dbg      out  current FSM state (0 = IDLE, 1 = WAIT)
// -----------------------------------------------------------------------------
module button_debounce_sched #(
  parameter int N_BTN     = 4,
  parameter int WIDTH_CNT = 24,
  parameter int CNT_W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_BTN-1:0]           btn_sync,
  output logic [N_BTN-1:0]           btn_stable,
  output logic [N_BTN-1:0]           press_pulse,
  output logic [N_BTN-1:0]           release_pulse,
  output logic                       busy,
  output logic [$clog2(N_BTN)-1:0]   active_idx,
  output logic [CNT_W-1:0]           press_total,
  output logic                       state_dbg
);

  localparam int IDX_W = $clog2(N_BTN);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  // Last timer value before commit: DEBOUNCE-1 = 0111...1
  localparam logic [WIDTH_CNT-1:0] TIMER_LAST = {1'b0, {(WIDTH_CNT-1){1'b1}}};

  logic [0:0]           state;
  logic [WIDTH_CNT-1:0] timer;
  logic [IDX_W-1:0]     ptr;
  logic [N_BTN-1:0]     pending;
  logic                 grant_found;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     cand_idx;
  int                   cand;

  assign pending   = btn_sync ^ btn_stable;
  assign busy      = (state == WAIT);
  assign state_dbg = state[0];

  // Round-robin search: start just after the last granted button (ptr) and
  // wrap around, so the most recently served button is considered last.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N_BTN) cand = cand - N_BTN;
      cand_idx = IDX_W'(cand);
      if (!grant_found && pending[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      ptr           <= IDX_W'(N_BTN - 1);
      btn_stable    <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      active_idx    <= '0;
      press_total   <= '0;
    end else begin
      // Pulses are high for exactly the cycle after a commit.
      press_pulse   <= '0;
      release_pulse <= '0;
      case (state)
        IDLE: begin
          if (grant_found) begin
            active_idx <= grant_idx;
            ptr        <= grant_idx;
            timer      <= '0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (btn_sync[active_idx] == btn_stable[active_idx]) begin
            // Bounced back before the debounce time: drop the grant.
            timer <= '0;
            state <= IDLE;
          end else if (timer == TIMER_LAST) begin
            btn_stable[active_idx] <= btn_sync[active_idx];
            if (btn_sync[active_idx]) begin
              press_pulse[active_idx] <= 1'b1;
              press_total             <= press_total + 1'b1;
            end else begin
              release_pulse[active_idx] <= 1'b1;
            end
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          timer <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debounce_sched.sv
// -----------------------------------------------------------------------------
// tb_button_debounce_sched
//
// Drives button_debounce_sched (N_BTN=4, WIDTH_CNT=4 -> DEBOUNCE=8, CNT_W=8)
// with directed scenarios followed by random button activity. A reference
// model tracks the grant by the cycle it started, and the commit happens when
// DEBOUNCE cycles have elapsed since then. Every cycle the model's outputs are
// compared with the DUT. Expected press_total values are queued when the model
// commits a press, and they are popped when the DUT pulses.
// -----------------------------------------------------------------------------
module tb_button_debounce_sched;

  localparam int N   = 4;
  localparam int WC  = 4;
  localparam int CW  = 8;
  localparam int DEB = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] btn_sync = '0;

  always #5 clk = ~clk;

  logic [N-1:0]  btn_stable;
  logic [N-1:0]  press_pulse;
  logic [N-1:0]  release_pulse;
  logic          busy;
  logic [1:0]    active_idx;
  logic [CW-1:0] press_total;
  logic          state_dbg;

  button_debounce_sched #(.N_BTN(N), .WIDTH_CNT(WC), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_sync      (btn_sync),
    .btn_stable    (btn_stable),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .busy          (busy),
    .active_idx    (active_idx),
    .press_total   (press_total),
    .state_dbg     (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [CW-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int           m_cycle = 0;
  bit           m_busy = 0;
  int           m_idx = 0;
  int           m_ptr = N - 1;
  int           m_grant_cycle = 0;
  bit [N-1:0]   m_stable = '0;
  bit [N-1:0]   m_press = '0;
  bit [N-1:0]   m_release = '0;
  int           m_total = 0;

  // Advances the model across one rising edge using the current inputs.
  task automatic model_step();
    bit [N-1:0] pend;
    m_press   = '0;
    m_release = '0;
    if (reset) begin
      m_busy   = 0;
      m_idx    = 0;
      m_ptr    = N - 1;
      m_stable = '0;
      m_total  = 0;
    end else if (!m_busy) begin
      pend = btn_sync ^ m_stable;
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!m_busy && pend[j]) begin
          m_busy        = 1;
          m_idx         = j;
          m_ptr         = j;
          m_grant_cycle = m_cycle;
        end
      end
    end else begin
      if (btn_sync[m_idx] == m_stable[m_idx]) begin
        m_busy = 0;
      end else if (m_cycle - m_grant_cycle == DEB) begin
        m_stable[m_idx] = btn_sync[m_idx];
        if (btn_sync[m_idx]) begin
          m_press[m_idx] = 1;
          m_total        = (m_total + 1) % 256;
          exp_q.push_back(CW'(m_total));
        end else begin
          m_release[m_idx] = 1;
        end
        m_busy = 0;
      end
    end
    m_cycle++;
  endtask

  task automatic compare_all();
    check_val("stable", btn_stable, m_stable);
    check_val("press", press_pulse, m_press);
    check_val("release", release_pulse, m_release);
    check_val("busy", busy, m_busy);
    check_val("state", state_dbg, m_busy);
    check_val("total", press_total, m_total);
    if (m_busy) check_val("active_idx", active_idx, m_idx);
    check_val("one_event", ($countones(press_pulse | release_pulse) <= 1), 1);
    if (press_pulse != '0) begin
      check_val("press_q_nonempty", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check_val("press_q_total", press_total, exp_q.pop_front());
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pcyc, rcyc, p0, p3, npulse;
    logic [CW-1:0] base;

    // 1: reset with all buttons high
    reset    = 1'b1;
    btn_sync = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("rst_stable", btn_stable, 0);
      check_val("rst_pulses", {press_pulse, release_pulse}, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_idx", active_idx, 0);
      check_val("rst_total", press_total, 0);
    end
    reset = 1'b0;
    tick();
    check_val("first_grant_busy", busy, 1);
    check_val("first_grant_idx", active_idx, 0);
    btn_sync = 4'h0;
    run(3);

    // 2: press and release of button 1
    btn_sync = 4'b0010;
    pcyc = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (t == 1) begin
        check_val("t2_busy_c1", busy, 1);
        check_val("t2_idx_c1", active_idx, 1);
      end
      if (press_pulse[1] && pcyc == 0) pcyc = t;
    end
    check_val("t2_press_cycle", pcyc, 9);
    check_val("t2_stable", btn_stable, 4'b0010);
    check_val("t2_total", press_total, 1);
    btn_sync = 4'b0000;
    rcyc = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (release_pulse[1] && rcyc == 0) rcyc = t;
    end
    check_val("t2_release_cycle", rcyc, 9);
    check_val("t2_total_after_rel", press_total, 1);

    // 3: short glitch on button 2
    btn_sync = 4'b0100;
    npulse = 0;
    for (int t = 1; t <= 12; t++) begin
      if (t == 4) btn_sync = 4'b0000;
      tick();
      npulse += $countones(press_pulse | release_pulse);
    end
    check_val("t3_no_pulse", npulse, 0);
    check_val("t3_stable", btn_stable, 0);
    check_val("t3_busy_low", busy, 0);

    // 4: buttons 0 and 3 together, served one after another
    reset = 1'b1;
    tick();
    reset = 1'b0;
    btn_sync = 4'b1001;
    p0 = 0;
    p3 = 0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (press_pulse[0] && p0 == 0) p0 = t;
      if (press_pulse[3] && p3 == 0) p3 = t;
    end
    check_val("t4_press0_cycle", p0, 9);
    check_val("t4_press3_cycle", p3, 18);
    btn_sync = 4'b0000;
    run(30);

    // 5: 256 press/release pairs on button 0, total wraps
    base = press_total;
    for (int i = 0; i < 256; i++) begin
      btn_sync = 4'b0001;
      run(10);
      btn_sync = 4'b0000;
      run(10);
    end
    check_val("t5_total_wrap", press_total, base);

    // 6: reset in the middle of a debounce on button 2
    btn_sync = 4'b1000;
    run(12);
    check_val("t6_pre_stable", btn_stable, 4'b1000);
    btn_sync = 4'b1100;
    run(6);
    check_val("t6_granted_2", active_idx, 2);
    reset = 1'b1;
    tick();
    check_val("t6_rst_stable", btn_stable, 0);
    check_val("t6_rst_busy", busy, 0);
    check_val("t6_rst_pulses", {press_pulse, release_pulse}, 0);
    reset = 1'b0;
    tick();
    check_val("t6_regrant_busy", busy, 1);
    check_val("t6_regrant_idx", active_idx, 2);
    run(30);
    btn_sync = 4'b0000;
    run(40);

    // Random activity: bit flips of random hold lengths, occasional reset
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 9) == 0) btn_sync[$urandom_range(0, N - 1)] ^= 1'b1;
      tick();
    end
    reset    = 1'b0;
    btn_sync = 4'b0000;
    run(60);
    check_val("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
